// File: rtl/io_read_buffer_pkg.sv
// Shared I/O read-buffer definitions: default sizes and the lowest-set-bit
// port selector used to arbitrate a multi-hot active vector.
package io_read_buffer_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH = 36;
  localparam int unsigned DEFAULT_PORT_COUNT = 8;
  localparam int unsigned MAX_PORT_COUNT     = 64;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic int unsigned lowest_set_index(input logic [MAX_PORT_COUNT-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_PORT_COUNT - 1; i >= 0; i--) begin
      if (vec[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/io_read_buffer_entry.sv
// One port of the I/O read buffer: a single-entry holding register with
// its occupancy flag. Ready is kept as a register so it never depends on
// the datapath select.
module io_read_buffer_entry
  import io_read_buffer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fill_valid,
  input  logic [WORD_WIDTH-1:0] fill_data,
  input  logic                  consume,
  output logic                  ready,
  output logic                  full,
  output logic [WORD_WIDTH-1:0] data
);

  logic fill_c;

  assign fill_c = fill_valid && ready;
  assign full   = !ready;

  // Occupancy: a fill is only taken while empty, a consume only while full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready <= 1'b1;
    end else if (fill_c) begin
      ready <= 1'b0;
    end else if (consume && !ready) begin
      ready <= 1'b1;
    end
  end

  // Word storage; contents are meaningless while the entry is empty.
  always_ff @(posedge clock) begin
    if (fill_c) data <= fill_data;
  end

endmodule

// File: rtl/io_read_buffer.sv
// I/O read buffer: PORT_COUNT one-entry buffers filled from the external
// side and drained one word per cycle by the datapath's active select.
// The lowest set active bit wins; an empty selected port reports a miss.
// Optional macro IO_READ_MISS_COUNT_EN adds a saturating miss counter.
module io_read_buffer
  import io_read_buffer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH       = DEFAULT_WORD_WIDTH,
  parameter int unsigned PORT_COUNT       = DEFAULT_PORT_COUNT,
  parameter int unsigned MISS_COUNT_WIDTH = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [PORT_COUNT-1:0]            active,
  input  logic [PORT_COUNT*WORD_WIDTH-1:0] in_data,
  input  logic [PORT_COUNT-1:0]            in_valid,
  output logic [PORT_COUNT-1:0]            in_ready,
  output logic [WORD_WIDTH-1:0]            read_data,
  output logic                             read_valid,
`ifdef IO_READ_MISS_COUNT_EN
  output logic [MISS_COUNT_WIDTH-1:0]      miss_count,
`endif
  output logic                             read_miss
);

  localparam int unsigned SEL_WIDTH = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  logic [PORT_COUNT-1:0] full;
  logic [PORT_COUNT-1:0] consume;
  logic [WORD_WIDTH-1:0] held [PORT_COUNT];
  logic [SEL_WIDTH-1:0]  sel_c;
  logic                  any_active_c;
  logic                  hit_c;
  logic                  miss_c;

  // Per-port single-entry buffers.
  for (genvar i = 0; i < PORT_COUNT; i++) begin : g_entry
    io_read_buffer_entry #(
      .WORD_WIDTH (WORD_WIDTH)
    ) u_entry (
      .clock      (clock),
      .reset      (reset),
      .fill_valid (in_valid[i]),
      .fill_data  (in_data[i*WORD_WIDTH +: WORD_WIDTH]),
      .consume    (consume[i]),
      .ready      (in_ready[i]),
      .full       (full[i]),
      .data       (held[i])
    );
  end

  // Arbitrate the active vector and decide hit or miss for the served port.
  always_comb begin
    sel_c        = SEL_WIDTH'(lowest_set_index(MAX_PORT_COUNT'(active)));
    any_active_c = |active;
    hit_c        = any_active_c && full[sel_c];
    miss_c       = any_active_c && !full[sel_c];
    consume      = '0;
    if (hit_c) consume[sel_c] = 1'b1;
  end

  // Registered read response, one cycle after the access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_valid <= 1'b0;
      read_miss  <= 1'b0;
      read_data  <= '0;
    end else begin
      read_valid <= hit_c;
      read_miss  <= miss_c;
      read_data  <= hit_c ? held[sel_c] : '0;
    end
  end

`ifdef IO_READ_MISS_COUNT_EN
  // Saturating miss counter, updated on the same edge that raises read_miss.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_count <= '0;
    end else if (miss_c && (miss_count != '1)) begin
      miss_count <= miss_count + MISS_COUNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: doc/io_read_buffer.md
IO_READ_BUFFER -- requirements
Module: io_read_buffer

Interface
REQ-001 Parameter WORD_WIDTH, default 36: width of one I/O data word.
REQ-002 Parameter PORT_COUNT, default 8: number of read ports; SHALL be at least 1.
REQ-003 Parameter MISS_COUNT_WIDTH, default 16: width of the miss counter.
REQ-004 clock  input  1: sole clock; all state updates on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 active  input  PORT_COUNT: registered per-port select from the I/O active stage; at most one bit is expected set.
REQ-007 in_data  input  PORT_COUNT*WORD_WIDTH: external write data; port i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-008 in_valid  input  PORT_COUNT: external write valid, one bit per port.
REQ-009 in_ready  output  PORT_COUNT: per-port ready to accept external data.
REQ-010 read_data  output  WORD_WIDTH: word delivered to the datapath.
REQ-011 read_valid  output  1: read_data holds a consumed word this cycle.
REQ-012 read_miss  output  1: the selected port was empty on its access.
REQ-013 miss_count  output  MISS_COUNT_WIDTH: saturating miss count; present only under IO_READ_MISS_COUNT_EN.

Function
REQ-014 Each port SHALL hold a one-entry buffer made of a full flag and a WORD_WIDTH data register.
REQ-015 in_ready[i] SHALL equal NOT full[i], driven from registered state only, with no path from active.
REQ-016 Fill: when in_valid[i] and in_ready[i] are both high, the block SHALL capture the port-i word and set full[i] at the next edge.
REQ-017 Consume: when active[i] and full[i] are both high, the block SHALL clear full[i] and, at the next edge, set read_data to buf[i] and read_valid to 1.
REQ-018 Miss: when active[i] is high and full[i] is low, the block SHALL, at the next edge, set read_miss to 1, set read_valid to 0, and set read_data to 0.
REQ-019 With no active bit set, the next cycle SHALL show read_valid=0, read_miss=0, read_data=0.
REQ-020 Latency from active to read_valid or read_miss SHALL be exactly 1 cycle, with no back-pressure toward the datapath.
REQ-021 If active is multi-hot, only the lowest set index SHALL be served; the other ports' state SHALL be unchanged.
REQ-022 An empty port that is active while in_valid is high SHALL report a miss and still accept the fill, with no bypass of the new word.
REQ-023 A full port SHALL drop nothing: in_ready stays low until that port is consumed.
REQ-024 Ports SHALL be independent: fills on several ports in one cycle are all accepted.

Reset
REQ-025 On reset, all full flags SHALL become 0, so all in_ready bits become 1.
REQ-026 On reset, read_valid, read_miss and read_data SHALL become 0.
REQ-027 On reset, miss_count SHALL become 0 when present.
REQ-028 Buffer data registers need no reset.
REQ-029 Reset asserted mid-operation SHALL discard buffered words, and any access in that cycle SHALL have no effect.

Configuration
REQ-030 With macro IO_READ_MISS_COUNT_EN defined, miss_count SHALL increment by 1 on every cycle that read_miss is set and SHALL saturate at all-ones.
REQ-031 Without IO_READ_MISS_COUNT_EN, the miss_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 A shared I/O package SHALL hold the default WORD_WIDTH and PORT_COUNT values and a function computing the lowest-set-bit index of the active vector.
REQ-033 One sub-module, io_read_buffer_entry, SHALL implement a single port's full flag, data register and in_ready, instantiated PORT_COUNT times.
REQ-034 Output select, miss logic and the miss counter SHALL reside in the top level.

Verification
REQ-035 Fill then read: after reset, drive in_valid[2]=1 with data 0x123456789 for 1 cycle, then active=0x04 -> next cycle read_valid=1 and read_data=0x123456789, then in_ready[2]=1.
REQ-036 Empty read: after reset, active=0x01 -> next cycle read_miss=1, read_valid=0, read_data=0, and miss_count=1 when enabled.
REQ-037 Full hold-off: fill port 5, then hold in_valid[5]=1 with new data for 3 cycles -> in_ready[5]=0 throughout and a later read returns the first word.
REQ-038 Multi-hot select: ports 1 and 3 full, active=0x0A -> port 1's word is returned, full[3] stays 1, and a next read with active=0x08 returns port 3's word.
REQ-039 Simultaneous miss and fill: port 0 empty with active=0x01 and in_valid[0]=1 in one cycle -> a miss is reported, then active=0x01 returns the new word.
REQ-040 Reset mid-operation: all ports full, pulse reset -> all in_ready=1 and a read gives read_miss=1; under IO_READ_MISS_COUNT_EN, 2^MISS_COUNT_WIDTH+4 misses leave miss_count all-ones.
